// File: rtl/prog_loader_pkg.sv
// Shared types and sizes for the program-memory loader.
package prog_loader_pkg;

    localparam int ADDR_W    = 6;
    localparam int CNT_W     = 7;
    localparam int MEM_DEPTH = 64;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/prog_loader_cksum.sv
// 8-bit running-sum accumulator used to validate the trailing checksum byte.
module prog_loader_cksum #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         add,
    input  logic [W-1:0] din,
    output logic         zero_with
);

    logic [W-1:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + din;
        end
    end

    // True when adding din to the running sum would give zero modulo 2^W.
    assign zero_with = ((sum + din) == '0);

endmodule

// File: rtl/prog_loader.sv
// Write-side loader for the 64x8 program memory: streams bytes to consecutive
// addresses. Define PROG_LOADER_CKSUM_EN to consume and verify a trailing checksum byte.
module prog_loader #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        base,
    input  logic [6:0]        len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [7:0]        mem_add,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import prog_loader_pkg::*;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remain;
    logic [CNT_W-1:0]  len_eff;
    logic              start_acc;
    logic              accept;
    logic              data_acc;

    assign len_eff   = (len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len;
    assign start_acc = (state == IDLE) && start;
    assign accept    = in_valid && in_ready;
    assign data_acc  = accept && (state == LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = (len_eff == '0) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                in_ready = (remain != '0);
                if (in_valid && in_ready && (remain == CNT_W'(1))) begin
`ifdef PROG_LOADER_CKSUM_EN
                    state_nx = CHECK;
`else
                    state_nx = FINISH;
`endif
                end
            end
`ifdef PROG_LOADER_CKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = FINISH;
                end
            end
`endif
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Write port is registered: the byte accepted on an edge is presented the cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            remain   <= '0;
            mem_we   <= 1'b0;
            mem_add  <= '0;
            mem_data <= '0;
        end else begin
            mem_we <= data_acc;
            if (start_acc) begin
                addr   <= base;
                remain <= len_eff;
            end else if (data_acc) begin
                addr     <= addr + ADDR_W'(1);
                remain   <= remain - CNT_W'(1);
                mem_add  <= {{(8-ADDR_W){1'b0}}, addr};
                mem_data <= in_data;
            end
        end
    end

`ifdef PROG_LOADER_CKSUM_EN
    logic ck_zero;
    logic err_q;

    prog_loader_cksum #(
        .W (DATA_W)
    ) u_cksum (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_acc),
        .add       (data_acc),
        .din       (in_data),
        .zero_with (ck_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if ((state == CHECK) && accept) begin
            err_q <= !ck_zero;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed/randomized bench for prog_loader with a queue-free array reference model.
module tb_prog_loader;

`ifdef PROG_LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [5:0] base     = '0;
    logic [6:0] len      = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = '0;
    logic       in_ready;
    logic [7:0] mem_add;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       busy;
    logic       done;
    logic       err;

    prog_loader #(
        .DEPTH  (64),
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_add  (mem_add),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural program memory fed by the DUT write port, and the expected image.
    logic [7:0] dut_mem [64];
    logic [7:0] exp_mem [64];
    always @(posedge clk) if (mem_we) dut_mem[mem_add[5:0]] <= mem_data;

    logic [5:0] last_add  = '0;
    logic [7:0] last_data = '0;
    logic       err_model = 1'b0;
    logic [7:0] pat [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_image(input string tag);
        int bad;
        bad = 0;
        for (int a = 0; a < 64; a++) if (dut_mem[a] !== exp_mem[a]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_add"},  mem_add,  0);
        check({tag, "_mem_data"}, mem_data, 0);
        check({tag, "_mem_we"},   mem_we,   0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_done"},     done,     0);
        check({tag, "_err"},      err,      0);
    endtask

    // stall_mode: 0 back-to-back, 1 valid pattern 1,0,0,1, 2 random.
    // rst_after >= 0 pulls reset once that many bytes have been written.
    task automatic do_load(input int b, input int l, input int stall_mode,
                           input bit mid_start, input bit bad_ck, input int rst_after);
        int         eff, need, n_acc, sum;
        logic [7:0] dat [64];
        logic [7:0] ck;
        bit         v, acc, wrote, fin, rst_arm;

        eff = (l > 64) ? 64 : l;
        sum = 0;
        for (int k = 0; k < 64; k++) begin
            dat[k] = (k < pat.size()) ? pat[k] : 8'($urandom);
            if (k < eff) sum += dat[k];
        end
        ck = 8'(256 - (sum % 256));
        if (bad_ck) ck = ck + 8'd1;
        need = (eff == 0) ? 0 : eff + (CK ? 1 : 0);

        @(negedge clk);
        base = 6'(b); len = 7'(l); start = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; base = 6'($urandom); len = 7'($urandom);
        err_model = 1'b0;
        check("start_busy", busy, 1);
        check("start_done", done, need == 0);
        check("start_we",   mem_we, 0);
        check("start_err",  err, err_model);

        n_acc = 0; fin = (need == 0); rst_arm = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            if (rst_arm) begin
                rst_n = 1'b0; in_valid = 1'b0;
                #1;
                check_all_zero("midrst");
                last_add = '0; last_data = '0; err_model = 1'b0;
                #2 rst_n = 1'b1;
                check_image("midrst_image");
                return;
            end
            case (stall_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            if (rst_after >= 0 && n_acc == rst_after) begin
                v = 1'b0; rst_arm = 1'b1;
            end
            in_valid = v;
            in_data  = (n_acc < eff) ? dat[n_acc] : (n_acc == eff) ? ck : 8'($urandom);
            if (mid_start && cyc == 3) begin
                start = 1'b1; base = 6'($urandom); len = 7'($urandom);
            end else begin
                start = 1'b0;
            end
            check("in_ready", in_ready, n_acc < need);
            check("busy", busy, 1);
            @(posedge clk); #1;
            acc   = v && (n_acc < need);
            wrote = acc && (n_acc < eff);
            if (wrote) begin
                last_add  = 6'(b + n_acc);
                last_data = dat[n_acc];
                exp_mem[last_add] = dat[n_acc];
            end
            if (acc && CK && n_acc == eff) err_model = bad_ck;
            if (acc) n_acc++;
            check("mem_we",   mem_we,   wrote);
            check("mem_add",  mem_add,  {2'b00, last_add});
            check("mem_data", mem_data, last_data);
            check("done",     done,     acc && (n_acc == need));
            check("err",      err,      err_model);
            if (acc && n_acc == need) fin = 1'b1;
        end
        start = 1'b0;
        if (!fin) begin
            check("load_timeout", n_acc, need);
            in_valid = 1'b0;
            return;
        end

        // FINISH (or the single len=0 cycle): extra byte offered must be refused.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'($urandom);
        if (need != 0) check("finish_ready", in_ready, 0);
        @(posedge clk); #1;
        check("end_busy", busy,   0);
        check("end_done", done,   0);
        check("end_we",   mem_we, 0);
        check("end_err",  err,    err_model);
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_ready", in_ready, 0);
        check_image("image");
    endtask

    initial begin
        for (int a = 0; a < 64; a++) begin
            dut_mem[a] = '0;
            exp_mem[a] = '0;
        end
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        pat = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(0, 4, 0, 1'b0, 1'b0, -1);
        pat.delete();

        do_load(62, 100, 0, 1'b0, 1'b0, -1);
        do_load(10, 9, 1, 1'b1, 1'b0, -1);
        do_load(20, 0, 0, 1'b0, 1'b0, -1);
        do_load(40, 5, 0, 1'b0, 1'b0, 2);
        do_load(60, 8, 0, 1'b0, 1'b0, -1);

        if (CK) begin
            pat = '{8'h01, 8'h02, 8'h03};
            do_load(5, 3, 0, 1'b0, 1'b0, -1);
            do_load(5, 3, 0, 1'b0, 1'b1, -1);
            pat.delete();
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("err_sticky", err, err_model);
            end
        end

        for (int i = 0; i < 6; i++) begin
            do_load($urandom_range(0, 63), $urandom_range(0, 80), 2, (i % 2) == 1,
                    CK && ($urandom_range(0, 1) == 1), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
